divider_ctrl: RTL and testbench
===============================

# divider_ctrl

Sequential restoring divider that steps one shared `subtractor` instance through the bits of an unsigned division, one quotient bit per clock. It sits between the host logic and the divider datapath. It accepts a start request, owns the partial-remainder and quotient registers, sequences the trial subtractions, and returns quotient and remainder with a one-cycle done pulse.

## Interface
- `nBit`, default 8: operand, quotient and remainder width; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only when not busy.
- `dividend`  in  nBit  unsigned dividend, captured on accepted start.
- `divisor`  in  nBit  unsigned divisor, captured on accepted start.
- `busy`  out  1  high while a division is in progress.
- `done`  out  1  single-cycle pulse when results become valid.
- `quotient`  out  nBit  result, held until the next accepted start.
- `remainder`  out  nBit  result, held until the next accepted start.
- `div_by_zero`  out  1  error flag; see Configuration.

## Operation
- States:
  - IDLE: reset state.
  - RUN: nBit iterations.
  - DONE: one cycle.
- Transitions:
  - IDLE or DONE with `start`=1: go to RUN. Capture `dividend` into Q and `divisor` into D, clear R, load iteration count with nBit.
  - IDLE with `start`=0: stay in IDLE.
  - DONE with `start`=0: go to IDLE.
  - RUN while count > 1: stay in RUN.
  - RUN on the last iteration: go to DONE.
- Iteration:
  - {R,Q} shifts left 1; the MSB of Q enters the LSB of R.
  - trial = {1'b0,R_shifted} − {1'b0,D}, computed on a `subtractor #(nBit+1)` instance; this is the only arithmetic resource.
  - If trial MSB = 0: R ← trial[nBit-1:0] and Q[0] ← 1.
  - Otherwise R keeps R_shifted and Q[0] ← 0.
- Register update: `quotient`/`remainder` load Q/R on the RUN→DONE transition only. They do not change during RUN and keep the previous results.
- `start` during RUN is ignored, with no queuing. Operand inputs are don't-care except on an accepted start.
- All arithmetic is unsigned, with no overflow case: quotient ≤ dividend and remainder < divisor for divisor ≠ 0.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, internal Q/R/D/count = 0.
- Reset asserted mid-RUN aborts the operation. After release the block is in IDLE and the next start behaves normally.
- Start latency:
  - `start` sampled high at edge E0: `busy`=1 after E0.
  - Iterations occur at edges E1..E(nBit−1); the final iteration at E(nBit) also loads the outputs.
- Done latency:
  - `done`=1 and `busy`=0 after E(nBit), i.e. nBit cycles after start.
  - `done` is high for exactly one cycle.
- Back-to-back: `start` held high during the DONE cycle is accepted, so `busy` rises again in the following cycle. Throughput is one division per nBit+1 cycles.
- `busy` and `done` are never high together.

## Configuration
- Macro: `DIVIDER_DBZ_DETECT_EN`.
- Defined:
  - An accepted start with `divisor`=0 goes directly to DONE instead of RUN.
  - Results: `quotient`=all ones, `remainder`=`dividend`, `div_by_zero`=1. `done` pulses 1 cycle after start.
  - `div_by_zero` holds until the next accepted start, which clears it.
- Undefined:
  - `div_by_zero` is tied to 0 and no zero check exists.
  - A zero divisor runs the normal nBit iterations. Every trial succeeds, so the result is again `quotient`=all ones and `remainder`=`dividend`, with done after nBit cycles.

## Test plan
- nBit=8, start with 100/7 → `done` 8 cycles after start; `quotient`=14, `remainder`=2; `busy` high for exactly 8 cycles.
- 255/1 then, with `start` held high in the DONE cycle, 5/9 → first result 255 rem 0; second accepted immediately, giving 0 rem 5 after 8 more cycles. `done` pulses each exactly once.
- Pulse `start` with 200/3 during RUN of 100/7 → the second request is ignored; the result is 14 rem 2 and no second `done` follows.
- Assert `rst_n`=0 at iteration 4 of 100/7 → all outputs 0 immediately. After release, 50/5 → 10 rem 0.
- 42/0 with `DIVIDER_DBZ_DETECT_EN` → `done` 1 cycle after start, `quotient`=255, `remainder`=42, `div_by_zero`=1. The next start of 9/3 clears the flag.
- 42/0 without the macro → `done` after 8 cycles, `quotient`=255, `remainder`=42, `div_by_zero`=0.

Source files
------------

// File: rtl/divider_ctrl.sv
// divider_ctrl: restoring divider, one quotient bit per clock through one shared subtractor.
// Optional zero-divisor shortcut and error flag enabled by defining DIVIDER_DBZ_DETECT_EN.

// subtractor: plain W-bit difference, the only arithmetic resource of the divider
module subtractor #(
    parameter int W = 9
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o
);
    assign diff_o = a_i - b_i;
endmodule

module divider_ctrl #(
    parameter int nBit = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [nBit-1:0] dividend,
    input  logic [nBit-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [nBit-1:0] quotient,
    output logic [nBit-1:0] remainder,
    output logic            div_by_zero
);
`ifdef DIVIDER_DBZ_DETECT_EN
    localparam bit DbzEn = 1'b1;
`else
    localparam bit DbzEn = 1'b0;
`endif
    localparam int CW = $clog2(nBit + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [nBit-1:0] q_q, r_q, d_q, quo_q, rem_q;
    logic [nBit-1:0] q_d, r_d;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, done_q, dbz_q;
    logic [nBit:0]   trial;

    // After k iterations R < 2^k, so R's MSB is still 0 whenever an iteration
    // runs; {R,Q_msb} is therefore the zero-extended shifted remainder.
    subtractor #(.W(nBit + 1)) u_sub (
        .a_i   ({r_q, q_q[nBit-1]}),
        .b_i   ({1'b0, d_q}),
        .diff_o(trial)
    );

    // Next partial remainder and quotient for one restoring step
    always_comb begin
        q_d = {q_q[nBit-2:0], ~trial[nBit]};
        r_d = trial[nBit] ? {r_q[nBit-2:0], q_q[nBit-1]} : trial[nBit-1:0];
    end

    // Control FSM with operand/iteration registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quo_q   <= q_d;
                        rem_q   <= r_d;
                    end
                end
                default: begin
                    if (start) begin
                        q_q   <= dividend;
                        d_q   <= divisor;
                        r_q   <= '0;
                        cnt_q <= CW'(nBit);
                        dbz_q <= 1'b0;
                        if (DbzEn && divisor == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            quo_q   <= '1;
                            rem_q   <= dividend;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = DbzEn ? dbz_q : 1'b0;
endmodule

// File: tb/tb_divider_ctrl.sv
// tb_divider_ctrl: randomized self-checking bench for divider_ctrl against an arithmetic model.
module tb_divider_ctrl;
    localparam int N = 8;
`ifdef DIVIDER_DBZ_DETECT_EN
    localparam bit DBZ = 1'b1;
`else
    localparam bit DBZ = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [N-1:0] quotient, remainder;

    int checks = 0;
    int errs = 0;

    always #5 clk = ~clk;

    divider_ctrl #(.nBit(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r,
                                  output logic z, output int lat);
        q   = (b == 0) ? {N{1'b1}} : a / b;
        r   = (b == 0) ? a : a % b;
        z   = DBZ && (b == 0);
        lat = (DBZ && b == 0) ? 0 : N;
    endfunction

    // Issue one start and wait for done; lat counts edges after the accepting edge.
    task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b, output int lat, output int bc);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = N'($urandom); divisor = N'($urandom);
        lat = 0; bc = 0;
        while (!done && lat < 40) begin
            bc += int'(busy);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errs++; $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero}); end
        checks++; if ({quotient, remainder} !== '0) begin errs++; $display("FAIL reset_results got %h want 0", {quotient, remainder}); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bc;
        run_div(8'd100, 8'd7, lat, bc);
        checks++; if (lat !== N) begin errs++; $display("FAIL basic_latency got %0d want %0d", lat, N); end
        checks++; if (bc !== N) begin errs++; $display("FAIL basic_busy_cycles got %0d want %0d", bc, N); end
        checks++; if ({quotient, remainder} !== {8'd14, 8'd2}) begin errs++; $display("FAIL basic_result got %0d r %0d want 14 r 2", quotient, remainder); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL basic_busy_with_done got %b want 0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errs++; $display("FAIL basic_done_pulse got %b want 0", done); end
    endtask

    task automatic test_random();
        int lat, bc, elat;
        logic [N-1:0] a, b, eq, er;
        logic ez;
        for (int i = 0; i < 24; i++) begin
            a = N'($urandom);
            b = (i % 6 == 5) ? '0 : N'($urandom_range(1, (i % 2) ? 15 : 255));
            model(a, b, eq, er, ez, elat);
            run_div(a, b, lat, bc);
            checks++; if (lat !== elat) begin errs++; $display("FAIL rand_latency %0d/%0d got %0d want %0d", a, b, lat, elat); end
            checks++; if ({quotient, remainder} !== {eq, er}) begin errs++; $display("FAIL rand_result %0d/%0d got %0d r %0d want %0d r %0d", a, b, quotient, remainder, eq, er); end
            checks++; if (div_by_zero !== ez) begin errs++; $display("FAIL rand_dbz %0d/%0d got %b want %b", a, b, div_by_zero, ez); end
            repeat (2) @(negedge clk);
            checks++; if ({quotient, remainder, div_by_zero} !== {eq, er, ez}) begin errs++; $display("FAIL rand_hold got %0d r %0d z %b want %0d r %0d z %b", quotient, remainder, div_by_zero, eq, er, ez); end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, pulses;
        run_div(8'd255, 8'd1, lat, bc);
        checks++; if ({quotient, remainder} !== {8'd255, 8'd0}) begin errs++; $display("FAIL b2b_first got %0d r %0d want 255 r 0", quotient, remainder); end
        start = 1'b1; dividend = 8'd5; divisor = 8'd9;
        @(negedge clk);
        start = 1'b0;
        checks++; if ({busy, done} !== 2'b10) begin errs++; $display("FAIL b2b_accept busy,done got %b want 10", {busy, done}); end
        lat = 0; pulses = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== N) begin errs++; $display("FAIL b2b_latency got %0d want %0d", lat, N); end
        checks++; if ({quotient, remainder} !== {8'd0, 8'd5}) begin errs++; $display("FAIL b2b_second got %0d r %0d want 0 r 5", quotient, remainder); end
        repeat (12) begin
            @(negedge clk);
            pulses += int'(done);
        end
        checks++; if (pulses !== 0) begin errs++; $display("FAIL b2b_extra_done got %0d want 0", pulses); end
    endtask

    task automatic test_ignore_start();
        int lat, pulses;
        logic [N-1:0] pq, pr;
        pq = quotient; pr = remainder;
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd3;
        @(negedge clk);
        start = 1'b0;
        checks++; if ({quotient, remainder} !== {pq, pr}) begin errs++; $display("FAIL ign_hold_during_run got %0d r %0d want %0d r %0d", quotient, remainder, pq, pr); end
        lat = 4;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== N) begin errs++; $display("FAIL ign_latency got %0d want %0d", lat, N); end
        checks++; if ({quotient, remainder} !== {8'd14, 8'd2}) begin errs++; $display("FAIL ign_result got %0d r %0d want 14 r 2", quotient, remainder); end
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            pulses += int'(done) + int'(busy);
        end
        checks++; if (pulses !== 0) begin errs++; $display("FAIL ign_second_op got %0d want 0", pulses); end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc;
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin errs++; $display("FAIL midreset_outputs got %b %b %b %0d %0d want all 0", busy, done, div_by_zero, quotient, remainder); end
        @(negedge clk);
        rst_n = 1'b1;
        run_div(8'd50, 8'd5, lat, bc);
        checks++; if ({quotient, remainder} !== {8'd10, 8'd0}) begin errs++; $display("FAIL midreset_next got %0d r %0d want 10 r 0", quotient, remainder); end
        checks++; if (lat !== N) begin errs++; $display("FAIL midreset_latency got %0d want %0d", lat, N); end
    endtask

    task automatic test_div_zero();
        int lat, bc, elat;
        logic [N-1:0] eq, er;
        logic ez;
        model(8'd42, 8'd0, eq, er, ez, elat);
        run_div(8'd42, 8'd0, lat, bc);
        checks++; if (lat !== elat) begin errs++; $display("FAIL dbz_latency got %0d want %0d", lat, elat); end
        checks++; if ({quotient, remainder, div_by_zero} !== {8'd255, 8'd42, ez}) begin errs++; $display("FAIL dbz_result got %0d r %0d z %b want 255 r 42 z %b", quotient, remainder, div_by_zero, ez); end
        run_div(8'd9, 8'd3, lat, bc);
        checks++; if ({quotient, remainder, div_by_zero} !== {8'd3, 8'd0, 1'b0}) begin errs++; $display("FAIL dbz_clear got %0d r %0d z %b want 3 r 0 z 0", quotient, remainder, div_by_zero); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_run();
        test_div_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end
endmodule
